sm83_irq_latch_bank: RTL and testbench

Parametrised, clocked interrupt-request latch bank for the SM83 core. It generalises the single-bit enable-gated IRQ latch to N channels. It adds an IE mask, a master enable (IME) with the EI delay slot, a fixed-priority vector select and a request/acknowledge handshake toward the core's dispatch sequencer. It sits between the peripheral request lines (VBlank, STAT, timer, serial, joypad) and the SM83 control unit, and also provides the IF register storage.

---
 rtl/sm83_irq_pkg.sv | 8 +
 rtl/sm83_irq_prio_enc.sv | 22 ++
 rtl/sm83_irq_latch_bank.sv | 69 ++++++
 tb/tb_sm83_irq_latch_bank.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sm83_irq_pkg.sv
// sm83_irq_pkg: shared types, limits and priority helper for the SM83 IRQ latch bank
package sm83_irq_pkg;
  localparam int SM83_IRQ_MAX_N = 16;
  typedef enum logic {IRQ_IDLE, IRQ_REQ} irq_state_t;
  function automatic logic [SM83_IRQ_MAX_N-1:0] prio_onehot(input logic [SM83_IRQ_MAX_N-1:0] v);
    return v & (~v + 1'b1);
  endfunction
endpackage

// File: rtl/sm83_irq_prio_enc.sv
// sm83_irq_prio_enc: fixed-priority encoder, lowest index wins
module sm83_irq_prio_enc
  import sm83_irq_pkg::*;
#(
  parameter int N  = 5,
  parameter int VW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pend,
  output logic          any,
  output logic [N-1:0]  onehot,
  output logic [VW-1:0] idx
);
  logic [SM83_IRQ_MAX_N-1:0] oh_full;
  assign oh_full = prio_onehot(SM83_IRQ_MAX_N'(pend));
  assign onehot  = oh_full[N-1:0];
  assign any     = |oh_full;
  // scan from the lowest priority up so the lowest pending index is left last
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = pend[i] ? VW'(i) : idx;
  end
endmodule

// File: rtl/sm83_irq_latch_bank.sv
// sm83_irq_latch_bank: IF storage, IME with EI slot and dispatch handshake; SM83_IRQ_EDGE_DETECT_EN selects edge-triggered IF set
module sm83_irq_latch_bank
  import sm83_irq_pkg::*;
#(
  parameter int N  = 5,
  parameter int VW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  ie,
  input  logic          if_we,
  input  logic [N-1:0]  if_wdata,
  input  logic          ei,
  input  logic          di,
  input  logic          irq_ack,
  output logic [N-1:0]  if_q,
  output logic          ime_q,
  output logic          wake,
  output logic          irq_valid,
  output logic [VW-1:0] irq_vec,
  output logic          irq_cancel
);
  logic [N-1:0]  pend, onehot, ack_clr, set_mask;
  logic [VW-1:0] idx;
  logic          any, ime, ei_dly;
  irq_state_t    state;
  assign pend = if_q & ie;
  sm83_irq_prio_enc #(.N(N), .VW(VW)) u_enc (
    .pend   (pend),
    .any    (any),
    .onehot (onehot),
    .idx    (idx)
  );
  assign wake       = any;
  assign ime_q      = ime;
  assign irq_valid  = state == IRQ_REQ;
  assign irq_vec    = irq_valid ? idx : '0;
  assign ack_clr    = (irq_valid && irq_ack) ? onehot : '0;
  assign irq_cancel = irq_valid && irq_ack && !any;
`ifdef SM83_IRQ_EDGE_DETECT_EN
  logic [N-1:0] req_d;
  // previous request levels so a held line sets IF only on its rising edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) req_d <= '0;
    else req_d <= req;
  assign set_mask = req & ~req_d;
`else
  assign set_mask = req;
`endif
  // IF latch: a new request beats both a software write and an ack-clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) if_q <= '0;
    else if_q <= ((if_we ? if_wdata : if_q) & ~ack_clr) | set_mask;
  // IME with one-instruction EI delay; DI and ack both kill it and any pending EI
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ime    <= 1'b0;
      ei_dly <= 1'b0;
    end else begin
      ime    <= (di || irq_ack) ? 1'b0 : ime | ei_dly;
      ei_dly <= (di || irq_ack) ? 1'b0 : ei;
    end
  // dispatch FSM: request while IME holds and something enabled is pending
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IRQ_IDLE;
    else if (state == IRQ_IDLE) state <= (ime && any && !di) ? IRQ_REQ : IRQ_IDLE;
    else state <= (irq_ack || di || !ime) ? IRQ_IDLE : IRQ_REQ;
endmodule

// File: tb/tb_sm83_irq_latch_bank.sv
// tb_sm83_irq_latch_bank: directed scoreboard bench for sm83_irq_latch_bank
module tb_sm83_irq_latch_bank;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] req = '0, ie = '0, if_wdata = '0;
  logic       if_we = 1'b0, ei = 1'b0, di = 1'b0, irq_ack = 1'b0;
  logic [4:0] if_q;
  logic       ime_q, wake, irq_valid, irq_cancel;
  logic [2:0] irq_vec;
  typedef struct {
    string      name;
    logic [4:0] ifq;
    logic       ime;
    logic       valid;
    logic [2:0] vec;
    logic       cancel;
    logic       wake;
  } exp_t;
  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
`ifdef SM83_IRQ_EDGE_DETECT_EN
  localparam logic [4:0] HELD_IF = 5'b00000;
`else
  localparam logic [4:0] HELD_IF = 5'b01000;
`endif
  sm83_irq_latch_bank #(.N(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .ie         (ie),
    .if_we      (if_we),
    .if_wdata   (if_wdata),
    .ei         (ei),
    .di         (di),
    .irq_ack    (irq_ack),
    .if_q       (if_q),
    .ime_q      (ime_q),
    .wake       (wake),
    .irq_valid  (irq_valid),
    .irq_vec    (irq_vec),
    .irq_cancel (irq_cancel)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [4:0] ifq, input logic ime, input logic valid,
                     input logic [2:0] vec, input logic cancel, input logic wk);
    exp_t e;
    e.name = name; e.ifq = ifq; e.ime = ime; e.valid = valid;
    e.vec = vec; e.cancel = cancel; e.wake = wk;
    q.push_back(e);
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (if_q !== e.ifq || ime_q !== e.ime || irq_valid !== e.valid || irq_vec !== e.vec ||
          irq_cancel !== e.cancel || wake !== e.wake) begin
        n_fail++;
        $display("FAIL %s: got if=%b ime=%b valid=%b vec=%0d cancel=%b wake=%b, want if=%b ime=%b valid=%b vec=%0d cancel=%b wake=%b",
                 e.name, if_q, ime_q, irq_valid, irq_vec, irq_cancel, wake,
                 e.ifq, e.ime, e.valid, e.vec, e.cancel, e.wake);
      end
    end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 5'b0, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
    ei = 1'b1;
    tick();
    ei = 1'b0;
    tick();
    ie = 5'b11111; req = 5'b10100;
    chk("prio_pre", 5'b00000, 1, 0, 0, 0, 0);
    tick();
    req = 5'b0;
    chk("prio_if", 5'b10100, 1, 0, 0, 0, 1);
    tick();
    chk("prio_req", 5'b10100, 1, 1, 2, 0, 1);
    tick();
    irq_ack = 1'b1;
    chk("prio_ack", 5'b10100, 1, 1, 2, 0, 1);
    tick();
    irq_ack = 1'b0;
    chk("prio_after", 5'b10000, 0, 0, 0, 0, 1);
    tick();
    ie = 5'b00010; ei = 1'b1;
    tick();
    ei = 1'b0;
    tick();
    req = 5'b00010;
    tick();
    req = 5'b0;
    tick();
    chk("sc_req", 5'b10010, 1, 1, 1, 0, 1);
    tick();
    req = 5'b00010; irq_ack = 1'b1;
    chk("sc_ack", 5'b10010, 1, 1, 1, 0, 1);
    tick();
    req = 5'b0; irq_ack = 1'b0;
    chk("sc_after", 5'b10010, 0, 0, 0, 0, 1);
    tick();
    ie = 5'b00001; if_we = 1'b1; if_wdata = 5'b00001; ei = 1'b1;
    tick();
    if_we = 1'b0; ei = 1'b0;
    tick();
    tick();
    chk("cn_req", 5'b00001, 1, 1, 0, 0, 1);
    tick();
    if_we = 1'b1; if_wdata = 5'b0;
    tick();
    irq_ack = 1'b1;
    chk("cn_ack", 5'b00000, 1, 1, 0, 1, 0);
    tick();
    if_we = 1'b0; irq_ack = 1'b0;
    chk("cn_after", 5'b00000, 0, 0, 0, 0, 0);
    tick();
    if_we = 1'b1; if_wdata = 5'b00001;
    tick();
    if_we = 1'b0; ei = 1'b1;
    chk("ei_c0", 5'b00001, 0, 0, 0, 0, 1);
    tick();
    ei = 1'b0;
    chk("ei_c1", 5'b00001, 0, 0, 0, 0, 1);
    tick();
    chk("ei_c2", 5'b00001, 1, 0, 0, 0, 1);
    tick();
    chk("ei_c3", 5'b00001, 1, 1, 0, 0, 1);
    tick();
    di = 1'b1;
    chk("di_c4", 5'b00001, 1, 1, 0, 0, 1);
    tick();
    di = 1'b0;
    chk("di_c5", 5'b00001, 0, 0, 0, 0, 1);
    tick();
    ei = 1'b1;
    tick();
    ei = 1'b0; di = 1'b1;
    chk("eidi_c1", 5'b00001, 0, 0, 0, 0, 1);
    tick();
    di = 1'b0;
    tick();
    chk("eidi_c3", 5'b00001, 0, 0, 0, 0, 1);
    tick();
    chk("eidi_c4", 5'b00001, 0, 0, 0, 0, 1);
    tick();
    ei = 1'b1;
    tick();
    ei = 1'b0;
    tick();
    tick();
    chk("rst_req", 5'b00001, 1, 1, 0, 0, 1);
    tick();
    reset_n = 1'b0;
    chk("rst_mid", 5'b00000, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
    chk("rst_rel", 5'b00000, 0, 0, 0, 0, 0);
    tick();
    ie = 5'b01000;
    for (int c = 0; c < 10; c++) begin
      req = 5'b01000;
      if_we = (c == 4); if_wdata = 5'b0;
      if (c == 3) chk("held_c3", 5'b01000, 0, 0, 0, 0, 1);
      if (c == 5) chk("held_c5", HELD_IF, 0, 0, 0, 0, |HELD_IF);
      if (c == 8) chk("held_c8", HELD_IF, 0, 0, 0, 0, |HELD_IF);
      tick();
    end
    req = 5'b0; if_we = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending checks, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
